// File: rtl/naive_bus_rr_arbiter.sv
// rtl/naive_bus_rr_arbiter.sv - N-master to 1-slave round-robin arbiter for the naive bus
module naive_bus_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int PTR_W       = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_MASTERS-1:0]    m_rd_req,
    output logic [NUM_MASTERS-1:0]    m_rd_gnt,
    input  logic [32*NUM_MASTERS-1:0] m_rd_addr,
    output logic [32*NUM_MASTERS-1:0] m_rd_data,
    input  logic [NUM_MASTERS-1:0]    m_wr_req,
    output logic [NUM_MASTERS-1:0]    m_wr_gnt,
    input  logic [32*NUM_MASTERS-1:0] m_wr_addr,
    input  logic [32*NUM_MASTERS-1:0] m_wr_data,
    input  logic [4*NUM_MASTERS-1:0]  m_wr_be,
    output logic                      s_rd_req,
    input  logic                      s_rd_gnt,
    output logic [31:0]               s_rd_addr,
    input  logic [31:0]               s_rd_data,
    output logic                      s_wr_req,
    input  logic                      s_wr_gnt,
    output logic [31:0]               s_wr_addr,
    output logic [31:0]               s_wr_data,
    output logic [3:0]                s_wr_be
);

    logic [NUM_MASTERS-1:0] req;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       rd_owner_q, rd_owner_d;
    logic                   rd_pending_q, rd_pending_d;
    logic [31:0]            rd_hold_q [NUM_MASTERS];
    logic [31:0]            rd_hold_d [NUM_MASTERS];

    logic [PTR_W-1:0]       winner, win_hi, win_lo, winner_inc;
    logic                   found_hi, found_lo, any_req;
    logic                   rd_fire, wr_fire;

    assign req = m_rd_req | m_wr_req;

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                found_lo = 1'b1;
                win_lo   = PTR_W'(i);
                if (i >= int'(rr_ptr_q)) begin
                    found_hi = 1'b1;
                    win_hi   = PTR_W'(i);
                end
            end
        end
    end

    assign winner  = found_hi ? win_hi : win_lo;
    assign any_req = found_lo;

    always_comb begin
        s_rd_req  = 1'b0;
        s_wr_req  = 1'b0;
        s_rd_addr = '0;
        s_wr_addr = '0;
        s_wr_data = '0;
        s_wr_be   = '0;
        if (rst_n && any_req) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (winner == PTR_W'(i)) begin
                    s_rd_req  = m_rd_req[i];
                    s_wr_req  = ~m_rd_req[i];
                    s_rd_addr = m_rd_addr[32*i +: 32];
                    s_wr_addr = m_wr_addr[32*i +: 32];
                    s_wr_data = m_wr_data[32*i +: 32];
                    s_wr_be   = m_wr_be[4*i +: 4];
                end
            end
        end
    end

    assign rd_fire = s_rd_req & s_rd_gnt;
    assign wr_fire = s_wr_req & s_wr_gnt;

    always_comb begin
        m_rd_gnt = '0;
        m_wr_gnt = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (winner == PTR_W'(i)) begin
                m_rd_gnt[i] = rd_fire;
                m_wr_gnt[i] = wr_fire;
            end
        end
    end

    assign winner_inc = (winner == PTR_W'(NUM_MASTERS - 1)) ? '0 : winner + PTR_W'(1);

    always_comb begin
        rr_ptr_d     = (rd_fire | wr_fire) ? winner_inc : rr_ptr_q;
        rd_pending_d = rd_fire;
        rd_owner_d   = rd_fire ? winner : rd_owner_q;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            rd_hold_d[i] = rd_hold_q[i];
            if (rd_pending_q && (rd_owner_q == PTR_W'(i))) begin
                rd_hold_d[i] = s_rd_data;
            end
        end
    end

    // The owner sees slave data combinationally; the hold register keeps it afterwards.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (rd_pending_q && (rd_owner_q == PTR_W'(i))) begin
                m_rd_data[32*i +: 32] = s_rd_data;
            end else begin
                m_rd_data[32*i +: 32] = rd_hold_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            rd_owner_q   <= '0;
            rd_pending_q <= 1'b0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                rd_hold_q[i] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            rd_owner_q   <= rd_owner_d;
            rd_pending_q <= rd_pending_d;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                rd_hold_q[i] <= rd_hold_d[i];
            end
        end
    end

endmodule

// File: doc/naive_bus_rr_arbiter.md
Name: naive_bus_rr_arbiter

Overview:
- N-master to 1-slave round-robin arbiter for the naive bus.
- Sits directly downstream of the core's instr_master and data_master, plus optional debug/DMA masters, and feeds a single slave port, normally the bus router input.
- Forwards at most one transaction per cycle and returns each read's data, one cycle after its grant, to the master that issued it.

Parameters:
NUM_MASTERS, 2, number of master ports (2..8)
PTR_W, 3, width of the round-robin pointer and owner index; must be at least clog2(NUM_MASTERS)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
m_rd_req  input  NUM_MASTERS  per-master read request
m_rd_gnt  output  NUM_MASTERS  per-master read grant
m_rd_addr  input  32*NUM_MASTERS  per-master read address, master i at [32i+31:32i]
m_rd_data  output  32*NUM_MASTERS  per-master read data, same slicing as m_rd_addr
m_wr_req  input  NUM_MASTERS  per-master write request
m_wr_gnt  output  NUM_MASTERS  per-master write grant
m_wr_addr  input  32*NUM_MASTERS  per-master write address
m_wr_data  input  32*NUM_MASTERS  per-master write data
m_wr_be  input  4*NUM_MASTERS  per-master write byte enables
s_rd_req  output  1  slave read request
s_rd_gnt  input  1  slave read grant
s_rd_addr  output  32  slave read address
s_rd_data  input  32  slave read data, valid the cycle after s_rd_gnt
s_wr_req  output  1  slave write request
s_wr_gnt  input  1  slave write grant
s_wr_addr  output  32  slave write address
s_wr_data  output  32  slave write data
s_wr_be  output  4  slave write byte enables

Behaviour:
- Reset: asynchronous, active-low, on rst_n.
  - rr_ptr=0, rd_pending=0, rd_owner=0.
  - All m_rd_data=0; all grants=0.
  - s_* request outputs=0; s_* address/data/be outputs=0.
- Request per master: req_i = m_rd_req[i] | m_wr_req[i]. If a master asserts both, its read is forwarded and its write waits.
- Arbitration (combinational, zero cycle):
  - Winner is the first i with req_i set, scanning rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS.
  - No requester: s_rd_req=s_wr_req=0, s_* address/data/be outputs=0.
- Forwarding: the winner's rd or wr request, address, data and be drive the s_* outputs. s_rd_req and s_wr_req are never both 1.
- Grant routing:
  - m_rd_gnt[winner]=s_rd_gnt & s_rd_req; m_wr_gnt[winner]=s_wr_gnt & s_wr_req.
  - Every other grant bit is 0.
- Pointer update on the clock edge:
  - Slave grant this cycle: rr_ptr <= (winner+1) mod NUM_MASTERS.
  - Otherwise rr_ptr holds, so the selection stays stable while a slave stalls.
- Stall and withdrawal: a master may drop its request before being granted; arbitration simply re-runs next cycle. No lock is held.
- Read return:
  - On a read grant: rd_pending<=1, rd_owner<=winner. On any cycle without a read grant: rd_pending<=0.
  - When rd_pending=1, m_rd_data[rd_owner] = s_rd_data (combinational); all other m_rd_data slices hold their last value.
  - Read latency grant-to-data: exactly 1 cycle, unchanged from the single-master bus.
- Back-to-back reads from different masters: rd_owner is re-registered every grant cycle, so cycle N+1 data goes to the cycle N grantee.
- Writes: fire-and-forget; no state recorded.
- Reset mid-operation: a pending read is discarded and rr_ptr returns to 0.
- Fairness: with all masters requesting continuously and the slave always granting, each master is granted once every NUM_MASTERS cycles.

Test Plan:
- Reset with all m_rd_req=2'b11 held and s_rd_gnt=0: all grants 0 and all m_rd_data=0 throughout reset. After release, s_rd_addr equals master 0's address and no grant occurs.
- NUM_MASTERS=2, both masters request reads continuously (m0 addr 0x100, m1 addr 0x200), s_rd_gnt=1, slave returns addr+1 next cycle:
  - grants alternate m0,m1,m0,...
  - m0 receives 0x101 and m1 receives 0x201, each exactly one cycle after its grant.
- m1 issues a write (addr 0x2000_0004, data 0xDEADBEEF, be 4'b0011) while m0 idles, s_wr_gnt=1: same cycle s_wr_* carry those exact values and m_wr_gnt=2'b10; rr_ptr becomes 0.
- Slave stall: both masters request, s_rd_gnt=0 for 5 cycles, then 1:
  - s_rd_addr stays constant during the stall;
  - exactly one grant fires on cycle 6, to the master at rr_ptr.
- m0 asserts rd_req and wr_req simultaneously: the read is forwarded first; the write is forwarded only after the read grant and after m1's turn if m1 is requesting.
- Reset asserted on the cycle after a read grant: the owner's m_rd_data stays 0 and rd_pending=0 after reset.
